// File: rtl/mat_trans_pkg.sv
// Shared types and defaults for the transpose-engine arbiter: FSM state
// encodings, tag type and parameter defaults.
package mat_trans_pkg;

  localparam int DEF_DW        = 32;
  localparam int DEF_BURST     = 64;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_TAG_DEPTH = 4;

  typedef logic [$clog2(DEF_NREQ)-1:0] tag_t;

  typedef enum logic [1:0] {
    I_IDLE   = 2'd0,
    I_REQ    = 2'd1,
    I_STREAM = 2'd2
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE   = 2'd0,
    O_REQ    = 2'd1,
    O_STREAM = 2'd2
  } out_state_e;

  // Tag width for n owners, never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_trans_tag_fifo.sv
// In-order owner-tag FIFO: one tag per burst accepted by the engine, popped
// when the matching transposed burst has fully drained.
module mat_trans_tag_fifo
  import mat_trans_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = DEF_TAG_DEPTH
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            do_push_s, do_pop_s;

  assign full_o    = (cnt_q == CNTW'(DEPTH));
  assign empty_o   = (cnt_q == CNTW'(0));
  assign rdata_o   = mem_q[rd_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer wrap and occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    wr_d  = do_push_s ? ((wr_q == AW'(DEPTH - 1)) ? AW'(0) : wr_q + AW'(1)) : wr_q;
    rd_d  = do_pop_s  ? ((rd_q == AW'(DEPTH - 1)) ? AW'(0) : rd_q + AW'(1)) : rd_q;
    cnt_d = cnt_q + CNTW'(do_push_s) - CNTW'(do_pop_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mat_trans_arb.sv
// Round-robin front end sharing one ping-pong transpose engine between NREQ
// sources, with transposed bursts steered back to the matching sink.
module mat_trans_arb
  import mat_trans_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int BURST     = DEF_BURST,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic [0:0]       clk_i,
  input  logic             rstn_i,
  input  logic [NREQ-1:0]  src_req_i,
  output logic [NREQ-1:0]  src_ack_o,
  input  logic [NREQ-1:0]  src_vld_i,
  input  logic [NREQ*DW-1:0] src_data_i,
  output logic             eng_in_req_o,
  input  logic             eng_in_ack_i,
  output logic             eng_in_vld_o,
  output logic [DW-1:0]    eng_in_data_o,
  input  logic             eng_out_req_i,
  output logic             eng_out_ack_o,
  input  logic             eng_out_vld_i,
  input  logic [DW-1:0]    eng_out_data_i,
  output logic [NREQ-1:0]  dst_req_o,
  input  logic [NREQ-1:0]  dst_ack_i,
  output logic [NREQ-1:0]  dst_vld_o,
  output logic [DW-1:0]    dst_data_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int TW = tag_w(NREQ);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  in_state_e  ist_q, ist_d;
  out_state_e ost_q, ost_d;
  logic [TW-1:0] g_q, g_d, rr_q, rr_d, d_q, d_d, pick_s, fifo_head_s;
  logic [CW-1:0] icnt_q, icnt_d, ocnt_q, ocnt_d;
  logic          err_q, err_d, found_s;
  logic          push_s, pop_s, fifo_full_s, fifo_empty_s;

  assign err_o  = err_q;
  assign busy_o = (ist_q != I_IDLE) || (ost_q != O_IDLE) || !fifo_empty_s;

  mat_trans_tag_fifo #(
    .W     (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i[0]),
    .rstn_i  (rstn_i),
    .push_i  (push_s),
    .wdata_i (g_q),
    .pop_i   (pop_s),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Round-robin pick: first requester at or after rr_q, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = g_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && src_req_i[(int'(rr_q) + i) % NREQ]) begin
        found_s = 1'b1;
        pick_s  = TW'((int'(rr_q) + i) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Input and output FSM registers.
  always_ff @(posedge clk_i[0]) begin
    if (!rstn_i) begin
      ist_q  <= I_IDLE;
      g_q    <= '0;
      rr_q   <= '0;
      icnt_q <= '0;
      ost_q  <= O_IDLE;
      d_q    <= '0;
      ocnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ist_q  <= ist_d;
      g_q    <= g_d;
      rr_q   <= rr_d;
      icnt_q <= icnt_d;
      ost_q  <= ost_d;
      d_q    <= d_d;
      ocnt_q <= ocnt_d;
      err_q  <= err_d;
    end
  end

  // Input FSM next state; a full tag FIFO only holds off new grants.
  always_comb begin
    ist_d  = ist_q;
    g_d    = g_q;
    rr_d   = rr_q;
    icnt_d = icnt_q;
    case (ist_q)
      I_IDLE: begin
        if (found_s && !fifo_full_s) begin
          g_d   = pick_s;
          ist_d = I_REQ;
        end else begin
          ist_d = I_IDLE;
        end
      end
      I_REQ: begin
        if (!src_req_i[g_q]) begin
          ist_d = I_IDLE;
        end else if (eng_in_ack_i) begin
          ist_d  = I_STREAM;
          icnt_d = '0;
        end else begin
          ist_d = I_REQ;
        end
      end
      I_STREAM: begin
        if (src_vld_i[g_q] && (icnt_q == CW'(BURST - 1))) begin
          ist_d  = I_IDLE;
          icnt_d = '0;
          rr_d   = (g_q == TW'(NREQ - 1)) ? TW'(0) : g_q + TW'(1);
        end else if (src_vld_i[g_q]) begin
          icnt_d = icnt_q + CW'(1);
        end else begin
          icnt_d = icnt_q;
        end
      end
      default: ist_d = I_IDLE;
    endcase
  end

  // Input-side outputs and tag push.
  always_comb begin
    src_ack_o     = '0;
    eng_in_req_o  = 1'b0;
    eng_in_vld_o  = 1'b0;
    eng_in_data_o = '0;
    push_s        = 1'b0;
    case (ist_q)
      I_REQ: begin
        eng_in_req_o = 1'b1;
        if (eng_in_ack_i && src_req_i[g_q]) begin
          src_ack_o[g_q] = 1'b1;
          push_s         = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      I_STREAM: begin
        eng_in_vld_o  = src_vld_i[g_q];
        eng_in_data_o = src_data_i[g_q*DW +: DW];
      end
      default: push_s = 1'b0;
    endcase
  end

  // Output FSM next state; engine read latency is absorbed by counting beats.
  always_comb begin
    ost_d  = ost_q;
    d_d    = d_q;
    ocnt_d = ocnt_q;
    err_d  = err_q;
    case (ost_q)
      O_IDLE: begin
        if (eng_out_req_i && !fifo_empty_s) begin
          d_d   = fifo_head_s;
          ost_d = O_REQ;
        end else if (eng_out_req_i) begin
          err_d = 1'b1;
        end else begin
          ost_d = O_IDLE;
        end
      end
      O_REQ: begin
        if (dst_ack_i[d_q]) begin
          ost_d  = O_STREAM;
          ocnt_d = '0;
        end else begin
          ost_d = O_REQ;
        end
      end
      O_STREAM: begin
        if (eng_out_vld_i && (ocnt_q == CW'(BURST - 1))) begin
          ost_d  = O_IDLE;
          ocnt_d = '0;
        end else if (eng_out_vld_i) begin
          ocnt_d = ocnt_q + CW'(1);
        end else begin
          ocnt_d = ocnt_q;
        end
      end
      default: ost_d = O_IDLE;
    endcase
  end

  // Output-side steering and tag pop on the final beat.
  always_comb begin
    dst_req_o     = '0;
    dst_vld_o     = '0;
    dst_data_o    = '0;
    eng_out_ack_o = 1'b0;
    pop_s         = 1'b0;
    case (ost_q)
      O_REQ: begin
        dst_req_o[d_q] = 1'b1;
        eng_out_ack_o  = dst_ack_i[d_q];
      end
      O_STREAM: begin
        dst_vld_o[d_q] = eng_out_vld_i;
        dst_data_o     = eng_out_data_i;
        pop_s          = eng_out_vld_i && (ocnt_q == CW'(BURST - 1));
      end
      default: pop_s = 1'b0;
    endcase
  end

endmodule
